// File: rtl/apb_cmd_queue_pkg.sv
// ---------------------------------------------------------------------------
// apb_cmd_queue_pkg : issue-FSM states and default widths. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package apb_cmd_queue_pkg;

  localparam int DEF_DATA_WIDTH     = 32;
  localparam int DEF_ADDR_WIDTH     = 32;
  localparam int DEF_CMD_DEPTH      = 4;
  localparam int DEF_WATCHDOG_CYCLE = 16;

  // One-hot encoding; Q_DRAIN is never entered and only names the illegal-state recovery.
  typedef enum logic [3:0] {
    Q_IDLE  = 4'b0001,
    Q_REQ   = 4'b0010,
    Q_GAP   = 4'b0100,
    Q_DRAIN = 4'b1000
  } q_state_e;

endpackage

`default_nettype wire

// File: rtl/apb_cmd_queue_if.sv
// ---------------------------------------------------------------------------
// apb_cmd_queue_if : producer, response and master-side signals. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface apb_cmd_queue_if
  import apb_cmd_queue_pkg::*;
#(
  parameter int APB_DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int APB_ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int CMD_DEPTH      = DEF_CMD_DEPTH
);
  localparam int STRB_WIDTH = APB_DATA_WIDTH / 8;
  localparam int CNT_W      = $clog2(CMD_DEPTH) + 1;

  logic                      cmd_valid_in;
  logic                      cmd_ready_out;
  logic [APB_ADDR_WIDTH-1:0] cmd_addr_in;
  logic                      cmd_write_in;
  logic [APB_DATA_WIDTH-1:0] cmd_wdata_in;
  logic [STRB_WIDTH-1:0]     cmd_strb_in;
  logic [2:0]                cmd_prot_in;
  logic [CNT_W-1:0]          cmd_count_out;

  logic                      rsp_valid_out;
  logic                      rsp_ready_in;
  logic [APB_DATA_WIDTH-1:0] rsp_rdata_out;
  logic                      rsp_error_out;

  logic                      other_sel_out;
  logic [APB_ADDR_WIDTH-1:0] other_addr_out;
  logic                      other_write_out;
  logic [APB_DATA_WIDTH-1:0] other_wdata_out;
  logic [STRB_WIDTH-1:0]     other_strb_out;
  logic [2:0]                other_prot_out;
  logic                      other_ready_in;
  logic [APB_DATA_WIDTH-1:0] other_rdata_in;
  logic                      other_error_in;

  modport slave (
    input  cmd_valid_in, cmd_addr_in, cmd_write_in, cmd_wdata_in, cmd_strb_in, cmd_prot_in,
    output cmd_ready_out, cmd_count_out,
    output rsp_valid_out, rsp_rdata_out, rsp_error_out,
    input  rsp_ready_in,
    output other_sel_out, other_addr_out, other_write_out, other_wdata_out, other_strb_out,
    output other_prot_out,
    input  other_ready_in, other_rdata_in, other_error_in
  );

  modport master (
    output cmd_valid_in, cmd_addr_in, cmd_write_in, cmd_wdata_in, cmd_strb_in, cmd_prot_in,
    input  cmd_ready_out, cmd_count_out,
    input  rsp_valid_out, rsp_rdata_out, rsp_error_out,
    output rsp_ready_in,
    input  other_sel_out, other_addr_out, other_write_out, other_wdata_out, other_strb_out,
    input  other_prot_out,
    output other_ready_in, other_rdata_in, other_error_in
  );

endinterface

`default_nettype wire

// File: rtl/apb_cmd_queue_sync_fifo.sv
// ---------------------------------------------------------------------------
// apb_cmd_queue_sync_fifo : synchronous FIFO, wrap-bit pointers, no fall-through. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module apb_cmd_queue_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  wire logic                     clk_in,
  input  wire logic                     rstn_in,
  input  wire logic                     push_in,
  input  wire logic [WIDTH-1:0]         wdata_in,
  input  wire logic                     pop_in,
  output logic      [WIDTH-1:0]         head_out,
  output logic                          full_out,
  output logic                          empty_out,
  output logic      [$clog2(DEPTH):0]   count_out
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic             do_push;
  logic             do_pop;

  assign full_out  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign empty_out = (wr_ptr_q == rd_ptr_q);
  assign count_out = wr_ptr_q - rd_ptr_q;
  assign head_out  = mem_q[rd_ptr_q[PTR_W-1:0]];

  assign do_push = push_in && !full_out;
  assign do_pop  = pop_in && !empty_out;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
  end

  always_ff @(posedge clk_in) begin
    if (!rstn_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: contents are only observed between push and pop.
  always_ff @(posedge clk_in) begin
    if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= wdata_in;
  end

endmodule

`default_nettype wire

// File: rtl/apb_cmd_queue.sv
// ---------------------------------------------------------------------------
// apb_cmd_queue : command FIFO, one-at-a-time issue FSM with watchdog, response slot. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module apb_cmd_queue
  import apb_cmd_queue_pkg::*;
#(
  parameter int APB_DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int APB_ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int CMD_DEPTH      = DEF_CMD_DEPTH,
  parameter int WATCHDOG_CYCLE = DEF_WATCHDOG_CYCLE
) (
  input  wire logic       apb_clk_in,
  input  wire logic       apb_rstn_in,
  apb_cmd_queue_if.slave  bus
);

  localparam int STRB_WIDTH = APB_DATA_WIDTH / 8;
  localparam int CNT_W      = $clog2(CMD_DEPTH) + 1;
  localparam int WD_W       = $clog2(WATCHDOG_CYCLE) + 1;
  localparam int FIFO_W     = APB_ADDR_WIDTH + 1 + APB_DATA_WIDTH + STRB_WIDTH + 3;

  q_state_e                  state_q, state_d;
  logic                      sel_q, sel_d;
  logic [APB_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                      write_q, write_d;
  logic [APB_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0]     strb_q, strb_d;
  logic [2:0]                prot_q, prot_d;
  logic [WD_W-1:0]           wd_q, wd_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic [APB_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                      rsp_error_q, rsp_error_d;

  logic                      fifo_push;
  logic                      fifo_pop;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [FIFO_W-1:0]         fifo_wdata;
  logic [FIFO_W-1:0]         fifo_head;
  logic [CNT_W-1:0]          fifo_count;
  logic [APB_ADDR_WIDTH-1:0] head_addr;
  logic                      head_write;
  logic [APB_DATA_WIDTH-1:0] head_wdata;
  logic [STRB_WIDTH-1:0]     head_strb;
  logic [2:0]                head_prot;
  logic                      rsp_slot_free;

  assign fifo_push  = bus.cmd_valid_in && !fifo_full;
  assign fifo_wdata = {bus.cmd_addr_in, bus.cmd_write_in, bus.cmd_wdata_in,
                       bus.cmd_strb_in, bus.cmd_prot_in};
  assign {head_addr, head_write, head_wdata, head_strb, head_prot} = fifo_head;

  apb_cmd_queue_sync_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (CMD_DEPTH)
  ) u_fifo (
    .clk_in    (apb_clk_in),
    .rstn_in   (apb_rstn_in),
    .push_in   (fifo_push),
    .wdata_in  (fifo_wdata),
    .pop_in    (fifo_pop),
    .head_out  (fifo_head),
    .full_out  (fifo_full),
    .empty_out (fifo_empty),
    .count_out (fifo_count)
  );

  // The slot counts as free in the same cycle its current response is being taken.
  assign rsp_slot_free = !rsp_valid_q || bus.rsp_ready_in;

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    addr_d      = addr_q;
    write_d     = write_q;
    wdata_d     = wdata_q;
    strb_d      = strb_q;
    prot_d      = prot_q;
    wd_d        = wd_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;
    fifo_pop    = 1'b0;

    if (rsp_valid_q && bus.rsp_ready_in) rsp_valid_d = 1'b0;

    case (state_q)
      Q_IDLE: begin
        sel_d = 1'b0;
        wd_d  = '0;
        if (!fifo_empty && rsp_slot_free) begin
          fifo_pop = 1'b1;
          addr_d   = head_addr;
          write_d  = head_write;
          wdata_d  = head_write ? head_wdata : '0;
          strb_d   = head_write ? head_strb  : '0;
          prot_d   = head_prot;
          sel_d    = 1'b1;
          state_d  = Q_REQ;
        end
      end
      Q_REQ: begin
        wd_d = wd_q + WD_W'(1);
        if (bus.other_ready_in) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = write_q ? '0 : bus.other_rdata_in;
          rsp_error_d = bus.other_error_in;
          sel_d       = 1'b0;
          state_d     = Q_GAP;
        end else if (wd_q == WD_W'(WATCHDOG_CYCLE - 1)) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_error_d = 1'b1;
          sel_d       = 1'b0;
          state_d     = Q_GAP;
        end
      end
      Q_GAP: begin
        sel_d = 1'b0;
        wd_d  = '0;
        if (!bus.other_ready_in) state_d = Q_IDLE;
      end
      default: begin
        sel_d   = 1'b0;
        wd_d    = '0;
        state_d = Q_IDLE;
      end
    endcase
  end

  always_ff @(posedge apb_clk_in) begin
    if (!apb_rstn_in) begin
      state_q     <= Q_IDLE;
      sel_q       <= 1'b0;
      addr_q      <= '0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      strb_q      <= '0;
      prot_q      <= '0;
      wd_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      wdata_q     <= wdata_d;
      strb_q      <= strb_d;
      prot_q      <= prot_d;
      wd_q        <= wd_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  assign bus.cmd_ready_out   = !fifo_full;
  assign bus.cmd_count_out   = fifo_count;
  assign bus.rsp_valid_out   = rsp_valid_q;
  assign bus.rsp_rdata_out   = rsp_rdata_q;
  assign bus.rsp_error_out   = rsp_error_q;
  assign bus.other_sel_out   = sel_q;
  assign bus.other_addr_out  = addr_q;
  assign bus.other_write_out = write_q;
  assign bus.other_wdata_out = wdata_q;
  assign bus.other_strb_out  = strb_q;
  assign bus.other_prot_out  = prot_q;

endmodule

`default_nettype wire

// File: tb/tb_apb_cmd_queue.sv
// ---------------------------------------------------------------------------
// tb_apb_cmd_queue : directed self-checking bench for apb_cmd_queue. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_apb_cmd_queue;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 4;
  localparam int WDOG  = 16;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  apb_cmd_queue_if #(.APB_DATA_WIDTH(DW), .APB_ADDR_WIDTH(AW), .CMD_DEPTH(DEPTH)) bus ();

  apb_cmd_queue #(
    .APB_DATA_WIDTH (DW),
    .APB_ADDR_WIDTH (AW),
    .CMD_DEPTH      (DEPTH),
    .WATCHDOG_CYCLE (WDOG)
  ) dut (
    .apb_clk_in  (clk),
    .apb_rstn_in (rstn),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [31:0] a, input logic w, input logic [31:0] d,
                      input logic [3:0] s, input logic [2:0] p);
    bus.cmd_addr_in  = a;
    bus.cmd_write_in = w;
    bus.cmd_wdata_in = d;
    bus.cmd_strb_in  = s;
    bus.cmd_prot_in  = p;
    bus.cmd_valid_in = 1'b1;
    step();
    bus.cmd_valid_in = 1'b0;
  endtask

  task automatic wait_sel(input string tag);
    int k = 0;
    while (!bus.other_sel_out && k < 20) begin
      step();
      k++;
    end
    check({tag, "_sel"}, 64'(bus.other_sel_out), 64'd1);
  endtask

  // Plays the master: waits for sel, stalls, completes, and checks the response.
  task automatic serve(input string tag, input logic [31:0] exp_addr, input logic [31:0] rdata,
                       input int waits, input logic [31:0] exp_rsp);
    wait_sel(tag);
    check({tag, "_addr"}, 64'(bus.other_addr_out), 64'(exp_addr));
    if (waits > 0) begin
      step(waits);
      check({tag, "_sel_held"}, 64'(bus.other_sel_out), 64'd1);
    end
    bus.other_ready_in = 1'b1;
    bus.other_rdata_in = rdata;
    step();
    bus.other_ready_in = 1'b0;
    bus.other_rdata_in = '0;
    check({tag, "_rsp_valid"}, 64'(bus.rsp_valid_out), 64'd1);
    check({tag, "_rsp_rdata"}, 64'(bus.rsp_rdata_out), 64'(exp_rsp));
    check({tag, "_rsp_error"}, 64'(bus.rsp_error_out), 64'd0);
    check({tag, "_sel_drop"},  64'(bus.other_sel_out), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic any_sel;
    logic held;

    bus.cmd_valid_in   = 1'b0;
    bus.cmd_addr_in    = '0;
    bus.cmd_write_in   = 1'b0;
    bus.cmd_wdata_in   = '0;
    bus.cmd_strb_in    = '0;
    bus.cmd_prot_in    = '0;
    bus.rsp_ready_in   = 1'b0;
    bus.other_ready_in = 1'b0;
    bus.other_rdata_in = '0;
    bus.other_error_in = 1'b0;

    // Reset state
    step(2);
    check("rst_ready", 64'(bus.cmd_ready_out), 64'd1);
    check("rst_count", 64'(bus.cmd_count_out), 64'd0);
    check("rst_sel",   64'(bus.other_sel_out), 64'd0);
    check("rst_addr",  64'(bus.other_addr_out), 64'd0);
    check("rst_rsp",   64'(bus.rsp_valid_out), 64'd0);
    rstn = 1'b1;
    step();

    // 1: single write with one wait state
    push(32'h0000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF, 3'b000);
    check("t1_count", 64'(bus.cmd_count_out), 64'd1);
    check("t1_sel_lat", 64'(bus.other_sel_out), 64'd0);
    step();
    check("t1_sel",   64'(bus.other_sel_out), 64'd1);
    check("t1_write", 64'(bus.other_write_out), 64'd1);
    check("t1_wdata", 64'(bus.other_wdata_out), 64'hDEAD_BEEF);
    check("t1_strb",  64'(bus.other_strb_out), 64'hF);
    serve("t1", 32'h0000_0010, 32'h5555_5555, 1, 32'h0);
    bus.rsp_ready_in = 1'b1;
    step();
    check("t1_rsp_clr", 64'(bus.rsp_valid_out), 64'd0);
    bus.rsp_ready_in = 1'b0;

    // 2: read, wdata/strb forced to zero on the master side
    push(32'h0000_0020, 1'b0, 32'hFFFF_FFFF, 4'hF, 3'b101);
    step();
    check("t2_write", 64'(bus.other_write_out), 64'd0);
    check("t2_wdata", 64'(bus.other_wdata_out), 64'd0);
    check("t2_strb",  64'(bus.other_strb_out), 64'd0);
    check("t2_prot",  64'(bus.other_prot_out), 64'd5);
    serve("t2", 32'h0000_0020, 32'h1234_5678, 0, 32'h1234_5678);
    step();
    check("t2_sel_low", 64'(bus.other_sel_out), 64'd0);
    bus.rsp_ready_in = 1'b1;
    step();
    check("t2_rsp_clr", 64'(bus.rsp_valid_out), 64'd0);

    // 3: fill the queue while the master stalls, then drain in order
    for (int i = 0; i < 5; i++) push(32'h100 + 32'(4 * i), 1'b0, 32'h0, 4'h0, 3'b000);
    check("t3_count_full", 64'(bus.cmd_count_out), 64'd4);
    check("t3_ready_full", 64'(bus.cmd_ready_out), 64'd0);
    push(32'h114, 1'b0, 32'h0, 4'h0, 3'b000);
    check("t3_count_rej", 64'(bus.cmd_count_out), 64'd4);
    serve("t3_0", 32'h100, 32'hA000_0100, 0, 32'hA000_0100);
    serve("t3_1", 32'h104, 32'hA000_0104, 0, 32'hA000_0104);
    serve("t3_2", 32'h108, 32'hA000_0108, 1, 32'hA000_0108);
    serve("t3_3", 32'h10C, 32'hA000_010C, 0, 32'hA000_010C);
    serve("t3_4", 32'h110, 32'hA000_0110, 0, 32'hA000_0110);
    step(3);
    check("t3_idle_sel", 64'(bus.other_sel_out), 64'd0);
    check("t3_empty",    64'(bus.cmd_count_out), 64'd0);

    // 4: watchdog completion with the master never ready
    bus.rsp_ready_in = 1'b0;
    push(32'h0000_0300, 1'b0, 32'h0, 4'h0, 3'b000);
    wait_sel("t4");
    step(WDOG - 1);
    check("t4_pre_valid", 64'(bus.rsp_valid_out), 64'd0);
    check("t4_pre_sel",   64'(bus.other_sel_out), 64'd1);
    step();
    check("t4_valid", 64'(bus.rsp_valid_out), 64'd1);
    check("t4_error", 64'(bus.rsp_error_out), 64'd1);
    check("t4_rdata", 64'(bus.rsp_rdata_out), 64'd0);
    check("t4_sel",   64'(bus.other_sel_out), 64'd0);
    bus.rsp_ready_in = 1'b1;
    step();
    check("t4_rsp_clr", 64'(bus.rsp_valid_out), 64'd0);
    bus.rsp_ready_in = 1'b0;

    // 5: response back-pressure blocks further issue
    push(32'h200, 1'b0, 32'h0, 4'h0, 3'b000);
    push(32'h204, 1'b0, 32'h0, 4'h0, 3'b000);
    push(32'h208, 1'b0, 32'h0, 4'h0, 3'b000);
    serve("t5_0", 32'h200, 32'h1111_2222, 0, 32'h1111_2222);
    any_sel = 1'b0;
    held    = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      any_sel = any_sel | bus.other_sel_out;
      if (!bus.rsp_valid_out || bus.rsp_rdata_out !== 32'h1111_2222) held = 1'b0;
    end
    check("t5_no_issue", 64'(any_sel), 64'd0);
    check("t5_rsp_held", 64'(held), 64'd1);
    check("t5_count",    64'(bus.cmd_count_out), 64'd2);
    bus.rsp_ready_in = 1'b1;
    step();
    check("t5_issue_sel",  64'(bus.other_sel_out), 64'd1);
    check("t5_issue_addr", 64'(bus.other_addr_out), 64'h204);
    check("t5_rsp_clr",    64'(bus.rsp_valid_out), 64'd0);
    serve("t5_1", 32'h204, 32'h3333_4444, 0, 32'h3333_4444);
    serve("t5_2", 32'h208, 32'h5555_6666, 0, 32'h5555_6666);
    step(3);

    // 6: reset during a transfer discards everything
    push(32'h400, 1'b0, 32'h0, 4'h0, 3'b000);
    push(32'h404, 1'b0, 32'h0, 4'h0, 3'b000);
    push(32'h408, 1'b0, 32'h0, 4'h0, 3'b000);
    check("t6_pre_count", 64'(bus.cmd_count_out), 64'd2);
    check("t6_pre_sel",   64'(bus.other_sel_out), 64'd1);
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    check("t6_sel",   64'(bus.other_sel_out), 64'd0);
    check("t6_count", 64'(bus.cmd_count_out), 64'd0);
    check("t6_rsp",   64'(bus.rsp_valid_out), 64'd0);
    check("t6_ready", 64'(bus.cmd_ready_out), 64'd1);
    step(3);
    check("t6_post_rsp", 64'(bus.rsp_valid_out), 64'd0);
    check("t6_post_sel", 64'(bus.other_sel_out), 64'd0);
    push(32'h500, 1'b1, 32'hCAFE_F00D, 4'h3, 3'b010);
    step();
    check("t6_new_wdata", 64'(bus.other_wdata_out), 64'hCAFE_F00D);
    serve("t6_new", 32'h500, 32'h9999_9999, 0, 32'h0);
    step(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
